// File: rtl/cross_bar_pkg.sv
// Purpose: shared constants and types for the 4x4 crossbar request/ack fabric.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cross_bar_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int NUM_SLAVES  = 4;
  localparam int ADDR_W      = 2;
  localparam int GRANT_W     = 3;

  // Arbiter grant code meaning "no master granted"; masters use 1..NUM_MASTERS.
  localparam logic [GRANT_W-1:0] GRANT_NONE = '0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/cb_timeout_cnt.sv
// Purpose: saturating wait-cycle counter with clear/enable and an expiry flag.
// Latency: expired is decoded from the registered count (no input-to-output path).
// Backpressure: none; TIMEOUT=0 pins the count at 0 and never expires.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear (wins over en)
//   en           : count one cycle
//   expired      : count has reached TIMEOUT-1
module cb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (TIMEOUT == 0 || clr) begin
      cnt <= '0;
    end else if (en && cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/cross_bar_master_port.sv
// Purpose: master-side crossbar port; holds one request toward the addressed slave's arbiter.
// Latency: accept -> xb_req next cycle; qualified slave ack -> master_ack next cycle.
// Backpressure: master_ready low while a transfer is outstanding; master_req ignored then.
//
// Ports:
//   master_*  : master side (req/addr/wr/wdata in; ready/ack/err/rdata out)
//   xb_*      : latched request toward the crossbar arbiters
//   slave_ack : per-slave ack, slave_grant : per-slave 3-bit grant code,
//   slave_rdata : per-slave read data (slice s valid with slave_ack[s])
module cross_bar_master_port
  import cross_bar_pkg::*;
#(
  parameter int MASTER  = 1,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         master_req,
  input  logic [ADDR_W-1:0]            master_addr,
  input  logic                         master_wr,
  input  logic [DATA_W-1:0]            master_wdata,
  output logic                         master_ready,
  output logic                         master_ack,
  output logic                         master_err,
  output logic [DATA_W-1:0]            master_rdata,
  output logic                         xb_req,
  output logic [ADDR_W-1:0]            xb_addr,
  output logic                         xb_wr,
  output logic [DATA_W-1:0]            xb_wdata,
  input  logic [NUM_SLAVES-1:0]        slave_ack,
  input  logic [NUM_SLAVES*GRANT_W-1:0] slave_grant,
  input  logic [NUM_SLAVES*DATA_W-1:0] slave_rdata
);

  localparam logic [GRANT_W-1:0] MY_GRANT = GRANT_W'(MASTER);

  state_t              state;
  logic                sel_ack;
  logic [GRANT_W-1:0]  sel_grant;
  logic [DATA_W-1:0]   sel_rdata;
  logic                complete;
  logic                expired;
  logic                timed_out;
  logic                accept;

  // Select the addressed slave's ack/grant/rdata using the latched index only.
  always_comb begin
    sel_ack   = 1'b0;
    sel_grant = GRANT_NONE;
    sel_rdata = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (xb_addr == ADDR_W'(s)) begin
        sel_ack   = slave_ack[s];
        sel_grant = slave_grant[s*GRANT_W +: GRANT_W];
        sel_rdata = slave_rdata[s*DATA_W +: DATA_W];
      end
    end
  end

  assign accept    = (state == IDLE) && master_req;
  // An ack only counts when the slave's arbiter is currently granting us.
  assign complete  = (state == WAIT) && sel_ack && (sel_grant == MY_GRANT);
  // Completion takes priority over a timeout landing in the same cycle.
  assign timed_out = (state == WAIT) && expired && !complete;

  cb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (complete ? 1'b0 : (state == WAIT)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      master_ack   <= 1'b0;
      master_err   <= 1'b0;
      master_rdata <= '0;
      xb_addr      <= '0;
      xb_wr        <= 1'b0;
      xb_wdata     <= '0;
    end else begin
      master_ack <= 1'b0;
      master_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (master_req) begin
            xb_addr  <= master_addr;
            xb_wr    <= master_wr;
            xb_wdata <= master_wdata;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (complete) begin
            state      <= IDLE;
            master_ack <= 1'b1;
            if (!xb_wr) begin
              master_rdata <= sel_rdata;
            end
          end else if (timed_out) begin
            state      <= IDLE;
            master_ack <= 1'b1;
            master_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from state so reset drops xb_req without waiting for a clock.
  assign master_ready = (state == IDLE);
  assign xb_req       = (state == WAIT);

endmodule

// File: tb/tb_cross_bar_master_port.sv
module tb_cross_bar_master_port;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          master_req;
  logic [1:0]    master_addr;
  logic          master_wr;
  logic [DW-1:0] master_wdata;
  logic          master_ready;
  logic          master_ack;
  logic          master_err;
  logic [DW-1:0] master_rdata;
  logic          xb_req;
  logic [1:0]    xb_addr;
  logic          xb_wr;
  logic [DW-1:0] xb_wdata;
  logic [3:0]    slave_ack;
  logic [11:0]   slave_grant;
  logic [4*DW-1:0] slave_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cross_bar_master_port #(
    .MASTER  (2),
    .DATA_W  (DW),
    .TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .master_req   (master_req),
    .master_addr  (master_addr),
    .master_wr    (master_wr),
    .master_wdata (master_wdata),
    .master_ready (master_ready),
    .master_ack   (master_ack),
    .master_err   (master_err),
    .master_rdata (master_rdata),
    .xb_req       (xb_req),
    .xb_addr      (xb_addr),
    .xb_wr        (xb_wr),
    .xb_wdata     (xb_wdata),
    .slave_ack    (slave_ack),
    .slave_grant  (slave_grant),
    .slave_rdata  (slave_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_slave(input int s, input logic [2:0] g, input logic a, input logic [DW-1:0] d);
    slave_grant[s*3 +: 3]   = g;
    slave_ack[s]            = a;
    slave_rdata[s*DW +: DW] = d;
  endtask

  task automatic clear_slaves();
    slave_ack   = '0;
    slave_grant = '0;
    slave_rdata = '0;
  endtask

  task automatic request(input logic [1:0] a, input logic w, input logic [DW-1:0] d);
    master_req   = 1'b1;
    master_addr  = a;
    master_wr    = w;
    master_wdata = d;
  endtask

  initial begin
    reset_n = 1'b0;
    master_req = 1'b0; master_addr = '0; master_wr = 1'b0; master_wdata = '0;
    clear_slaves();
    #3;
    // Reset state
    check("rst_ready",  {31'd0, master_ready}, 32'd1);
    check("rst_ack",    {31'd0, master_ack},   32'd0);
    check("rst_err",    {31'd0, master_err},   32'd0);
    check("rst_rdata",  master_rdata,          32'd0);
    check("rst_xb_req", {31'd0, xb_req},       32'd0);
    check("rst_xb_addr",{30'd0, xb_addr},      32'd0);
    check("rst_xb_wr",  {31'd0, xb_wr},        32'd0);
    check("rst_xb_wd",  xb_wdata,              32'd0);
    @(negedge clk); reset_n = 1'b1;
    tick();

    // Read, immediate grant
    request(2'd1, 1'b0, 32'h0);
    tick();
    master_req = 1'b0;
    check("rd_xb_req",  {31'd0, xb_req},       32'd1);
    check("rd_ready0",  {31'd0, master_ready}, 32'd0);
    check("rd_xb_addr", {30'd0, xb_addr},      32'd1);
    drive_slave(1, 3'd2, 1'b1, 32'hA5A5_0001);
    tick();
    clear_slaves();
    check("rd_ack",     {31'd0, master_ack},   32'd1);
    check("rd_err",     {31'd0, master_err},   32'd0);
    check("rd_rdata",   master_rdata,          32'hA5A5_0001);
    check("rd_ready1",  {31'd0, master_ready}, 32'd1);
    check("rd_xb_req0", {31'd0, xb_req},       32'd0);
    tick();
    check("rd_ack_pulse", {31'd0, master_ack}, 32'd0);

    // Write with contention
    request(2'd3, 1'b1, 32'h1234);
    tick();                                  // cycle 1
    master_req = 1'b0; master_wdata = 32'hFFFF; master_addr = 2'd0; master_wr = 1'b0;
    check("wr_xb_wd1",  xb_wdata,              32'h1234);
    check("wr_xb_wr",   {31'd0, xb_wr},        32'd1);
    check("wr_xb_addr", {30'd0, xb_addr},      32'd3);
    tick();                                  // cycle 2: other master granted
    drive_slave(3, 3'd1, 1'b1, 32'hDEAD);
    tick();                                  // cycle 3
    clear_slaves();
    check("wr_no_ack",  {31'd0, master_ack},   32'd0);
    check("wr_req_hold",{31'd0, xb_req},       32'd1);
    tick();                                  // cycle 4
    check("wr_xb_wd4",  xb_wdata,              32'h1234);
    tick();                                  // cycle 5: our grant
    drive_slave(3, 3'd2, 1'b1, 32'hBEEF);
    tick();                                  // cycle 6
    clear_slaves();
    check("wr_ack",     {31'd0, master_ack},   32'd1);
    check("wr_err",     {31'd0, master_err},   32'd0);
    check("wr_rdata",   master_rdata,          32'hA5A5_0001);

    // Wrong-slave ack, then let the transfer time out
    tick();
    request(2'd0, 1'b0, 32'h0);
    tick();                                  // cycle 1, counter 0
    master_req = 1'b0;
    drive_slave(2, 3'd2, 1'b1, 32'h5555);
    tick();                                  // cycle 2
    clear_slaves();
    for (int c = 2; c < 9; c++) begin
      check("to_no_ack", {31'd0, master_ack}, 32'd0);
      check("to_req",    {31'd0, xb_req},     32'd1);
      tick();
    end                                      // cycle 9
    check("to_ack",     {31'd0, master_ack},   32'd1);
    check("to_err",     {31'd0, master_err},   32'd1);
    check("to_xb_req0", {31'd0, xb_req},       32'd0);
    check("to_rdata",   master_rdata,          32'hA5A5_0001);
    tick();
    check("to_err_pulse", {31'd0, master_err}, 32'd0);

    // Ack on the expiry cycle: completion wins
    request(2'd0, 1'b0, 32'h0);
    tick();                                  // cycle 1
    master_req = 1'b0;
    repeat (7) tick();                       // cycle 8, counter 7
    drive_slave(0, 3'd2, 1'b1, 32'h77);
    tick();                                  // cycle 9
    clear_slaves();
    check("tie_ack",    {31'd0, master_ack},   32'd1);
    check("tie_err",    {31'd0, master_err},   32'd0);
    check("tie_rdata",  master_rdata,          32'h77);

    // Reset during the second WAIT cycle
    tick();
    request(2'd2, 1'b1, 32'h55);
    tick();                                  // cycle 1
    master_req = 1'b0;
    tick();                                  // cycle 2
    check("mr_req_pre", {31'd0, xb_req},       32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mr_xb_req",  {31'd0, xb_req},       32'd0);
    check("mr_ready",   {31'd0, master_ready}, 32'd1);
    check("mr_ack",     {31'd0, master_ack},   32'd0);
    check("mr_err",     {31'd0, master_err},   32'd0);
    check("mr_rdata",   master_rdata,          32'd0);
    check("mr_xb_addr", {30'd0, xb_addr},      32'd0);
    check("mr_xb_wd",   xb_wdata,              32'd0);
    @(negedge clk); reset_n = 1'b1;
    tick();
    check("mr_idle_ack",{31'd0, master_ack},   32'd0);
    request(2'd1, 1'b0, 32'h0);
    tick();
    master_req = 1'b0;
    check("mr_new_req", {31'd0, xb_req},       32'd1);
    check("mr_new_addr",{30'd0, xb_addr},      32'd1);
    drive_slave(1, 3'd2, 1'b1, 32'h99);
    tick();
    clear_slaves();
    check("mr_new_ack", {31'd0, master_ack},   32'd1);
    check("mr_new_rd",  master_rdata,          32'h99);

    // Back-to-back with master_req held high
    tick();
    request(2'd1, 1'b0, 32'h0);
    tick();                                  // cycle 1
    master_addr = 2'd2;
    drive_slave(1, 3'd2, 1'b1, 32'h1111);
    tick();                                  // cycle 2
    clear_slaves();
    check("bb_ack1",    {31'd0, master_ack},   32'd1);
    check("bb_rd1",     master_rdata,          32'h1111);
    check("bb_ready",   {31'd0, master_ready}, 32'd1);
    tick();                                  // cycle 3
    master_req = 1'b0;
    check("bb_req2",    {31'd0, xb_req},       32'd1);
    check("bb_addr2",   {30'd0, xb_addr},      32'd2);
    check("bb_gap",     {31'd0, master_ack},   32'd0);
    drive_slave(2, 3'd2, 1'b1, 32'h2222);
    tick();                                  // cycle 4
    clear_slaves();
    check("bb_ack2",    {31'd0, master_ack},   32'd1);
    check("bb_rd2",     master_rdata,          32'h2222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed no finish, expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
